// File: rtl/float64_pkg.sv
// Shared constants and types for the binary64 soft-float front ends.
// Field positions, exponent limits, exception flag values and the unpacker state encoding.
package float64_pkg;

    localparam int EXP_BIAS = 1023;
    localparam logic [10:0] EXP_MAX = 11'd2047;

    localparam logic [31:0] FLAG_INEXACT   = 32'd1;
    localparam logic [31:0] FLAG_UNDERFLOW = 32'd4;
    localparam logic [31:0] FLAG_OVERFLOW  = 32'd8;
    localparam logic [31:0] FLAG_INVALID   = 32'd16;

    localparam int SIGN_BIT   = 63;
    localparam int EXP_MSB    = 62;
    localparam int EXP_LSB    = 52;
    localparam int FRAC_MSB   = 51;
    localparam int HIDDEN_BIT = 52;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_NORM = 3'b010,
        ST_DONE = 3'b100
    } state_t;

endpackage

// File: rtl/float64_classify.sv
// Combinational classifier: splits a packed binary64 word into class bits and the
// starting exponent/significand for unpacking (subnormals still need normalization).
module float64_classify
    import float64_pkg::*;
(
    input  logic [63:0] i_a,
    output logic        o_sign,
    output logic        o_is_zero,
    output logic        o_is_inf,
    output logic        o_is_nan,
    output logic        o_is_snan,
    output logic        o_is_sub,
    output logic [11:0] o_exp,
    output logic [63:0] o_sig
);

    logic [10:0] w_exp;
    logic [51:0] w_frac;
    logic        w_frac_zero;

    assign w_exp       = i_a[EXP_MSB:EXP_LSB];
    assign w_frac      = i_a[FRAC_MSB:0];
    assign w_frac_zero = (w_frac == 52'd0);
    assign o_sign      = i_a[SIGN_BIT];

    always_comb begin
        o_is_zero = 1'b0;
        o_is_inf  = 1'b0;
        o_is_nan  = 1'b0;
        o_is_snan = 1'b0;
        o_is_sub  = 1'b0;
        o_exp     = 12'd0;
        o_sig     = 64'd0;
        if (w_exp == EXP_MAX) begin
            o_exp = {1'b0, EXP_MAX};
            if (w_frac_zero) begin
                o_is_inf = 1'b1;
            end else begin
                // The quiet bit is the fraction MSB; clear means signalling.
                o_is_nan  = 1'b1;
                o_is_snan = ~w_frac[FRAC_MSB];
                o_sig     = {12'b0, w_frac};
            end
        end else if (w_exp == 11'd0) begin
            if (w_frac_zero) begin
                o_is_zero = 1'b1;
            end else begin
                o_is_sub = 1'b1;
                o_exp    = 12'd1;
                o_sig    = {12'b0, w_frac};
            end
        end else begin
            o_exp = {1'b0, w_exp};
            o_sig = {11'b0, 1'b1, w_frac};
        end
    end

endmodule

// File: rtl/unpack_float64.sv
// Multi-cycle binary64 unpacker with ap_ctrl_hs handshake. Subnormals are normalized
// one bit per cycle in NORM; signalling NaNs raise the invalid flag on the done cycle.
module unpack_float64
    import float64_pkg::*;
(
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic [63:0] a,
    input  logic [31:0] float_exception_flag_i,
    output logic [31:0] float_exception_flag_o,
    output logic        float_exception_flag_o_ap_vld,
    output logic        zSign,
    output logic [11:0] zExp,
    output logic [63:0] zSig,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan,
    output logic        is_snan,
    output logic [2:0]  o_dbg_state
);

    state_t      r_state;
    logic        r_sign;
    logic [11:0] r_exp;
    logic [63:0] r_sig;
    logic        r_is_zero;
    logic        r_is_inf;
    logic        r_is_nan;
    logic        r_is_snan;

    logic        w_sign;
    logic        w_is_zero;
    logic        w_is_inf;
    logic        w_is_nan;
    logic        w_is_snan;
    logic        w_is_sub;
    logic [11:0] w_exp;
    logic [63:0] w_sig;

    float64_classify u_classify (
        .i_a       (a),
        .o_sign    (w_sign),
        .o_is_zero (w_is_zero),
        .o_is_inf  (w_is_inf),
        .o_is_nan  (w_is_nan),
        .o_is_snan (w_is_snan),
        .o_is_sub  (w_is_sub),
        .o_exp     (w_exp),
        .o_sig     (w_sig)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state   <= ST_IDLE;
            r_sign    <= 1'b0;
            r_exp     <= 12'd0;
            r_sig     <= 64'd0;
            r_is_zero <= 1'b0;
            r_is_inf  <= 1'b0;
            r_is_nan  <= 1'b0;
            r_is_snan <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ap_start) begin
                        r_sign    <= w_sign;
                        r_exp     <= w_exp;
                        r_sig     <= w_sig;
                        r_is_zero <= w_is_zero;
                        r_is_inf  <= w_is_inf;
                        r_is_nan  <= w_is_nan;
                        r_is_snan <= w_is_snan;
                        r_state   <= w_is_sub ? ST_NORM : ST_DONE;
                    end
                end
                ST_NORM: begin
                    // Exponent may go negative; 12-bit two's complement covers down to -51.
                    if (r_sig[HIDDEN_BIT]) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_sig <= {r_sig[62:0], 1'b0};
                        r_exp <= r_exp - 12'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ap_done  = (r_state == ST_DONE);
    assign ap_ready = ap_done;
    assign ap_idle  = (r_state == ST_IDLE) && !ap_start;

    assign float_exception_flag_o_ap_vld = ap_done && r_is_snan;
    assign float_exception_flag_o = float_exception_flag_o_ap_vld
                                    ? (float_exception_flag_i | FLAG_INVALID)
                                    : float_exception_flag_i;

    assign zSign       = r_sign;
    assign zExp        = r_exp;
    assign zSig        = r_sig;
    assign is_zero     = r_is_zero;
    assign is_inf      = r_is_inf;
    assign is_nan      = r_is_nan;
    assign is_snan     = r_is_snan;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_unpack_float64.sv
// Scoreboard bench for unpack_float64: driver pushes model results with expected done cycle,
// a monitor pops and compares on each ap_done and checks the flag side channel otherwise.
module tb_unpack_float64;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [63:0] a;
  logic [31:0] flag_i;
  logic [31:0] flag_o;
  logic        flag_vld;
  logic        z_sign;
  logic [11:0] z_exp;
  logic [63:0] z_sig;
  logic        is_zero, is_inf, is_nan, is_snan;
  logic [2:0]  dbg_state;

  int cyc = 0;
  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    logic [80:0] res;     // {sign, exp, sig, zero, inf, nan, snan}
    logic [31:0] flag;
    logic        vld;
    int          done_cyc;
  } exp_t;

  exp_t exp_q[$];

  unpack_float64 dut (
    .ap_clk                        (ap_clk),
    .ap_rst_n                      (ap_rst_n),
    .ap_start                      (ap_start),
    .ap_done                       (ap_done),
    .ap_idle                       (ap_idle),
    .ap_ready                      (ap_ready),
    .a                             (a),
    .float_exception_flag_i        (flag_i),
    .float_exception_flag_o        (flag_o),
    .float_exception_flag_o_ap_vld (flag_vld),
    .zSign                         (z_sign),
    .zExp                          (z_exp),
    .zSig                          (z_sig),
    .is_zero                       (is_zero),
    .is_inf                        (is_inf),
    .is_nan                        (is_nan),
    .is_snan                       (is_snan),
    .o_dbg_state                   (dbg_state)
  );

  // clock / reset
  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // reference model: IEEE-754 field rules, normalization by leading-one position
  function automatic exp_t model(input logic [63:0] op, input logic [31:0] fi, input int start_cyc);
    exp_t m;
    int e;
    logic [51:0] f;
    logic [11:0] ze;
    logic [63:0] zs;
    logic cz, ci, cn, cs;
    int p;
    int shift;
    int lat;
    e = int'(op[62:52]);
    f = op[51:0];
    cz = 0; ci = 0; cn = 0; cs = 0;
    lat = 1;
    m.flag = fi;
    m.vld = 1'b0;
    if (e == 0 && f == 0) begin
      ze = 12'd0; zs = 64'd0; cz = 1;
    end else if (e == 0) begin
      p = 0;
      for (int i = 0; i < 52; i++) if (f[i]) p = i;
      shift = 52 - p;
      zs = 64'(f) << shift;
      ze = 12'(1 - shift);
      lat = shift + 2;
    end else if (e == 2047) begin
      ze = 12'd2047;
      if (f == 0) begin
        zs = 64'd0; ci = 1;
      end else begin
        zs = 64'(f); cn = 1; cs = !f[51];
        if (cs) begin
          m.flag = fi | 32'd16;
          m.vld = 1'b1;
        end
      end
    end else begin
      ze = 12'(e);
      zs = 64'(f) + (64'd1 << 52);
    end
    m.res = {op[63], ze, zs, cz, ci, cn, cs};
    m.done_cyc = start_cyc + lat;
    return m;
  endfunction

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge ap_clk);
      #2;
      if (ap_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 128'(dbg_state), 128'd0);
        end else begin
          e = exp_q.pop_front();
          chk("result", 128'({z_sign, z_exp, z_sig, is_zero, is_inf, is_nan, is_snan}), 128'(e.res));
          chk("done_cycle", 128'(cyc), 128'(e.done_cyc));
          chk("done_flags", 128'({ap_ready, ap_idle, flag_vld, flag_o}), 128'({1'b1, 1'b0, e.vld, e.flag}));
        end
      end else begin
        chk("idle_flags", 128'({ap_ready, flag_vld, flag_o}), 128'({1'b0, 1'b0, flag_i}));
      end
    end
  end

  // driver tasks
  task automatic issue(input logic [63:0] op, input logic [31:0] fi);
    @(negedge ap_clk);
    a = op;
    flag_i = fi;
    ap_start = 1'b1;
    exp_q.push_back(model(op, fi, cyc));
    @(negedge ap_clk);
    ap_start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge ap_clk);
      #3;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, 128'({z_sign, z_exp, z_sig, is_zero, is_inf, is_nan, is_snan, ap_done, ap_ready, flag_vld}), 128'd0);
    chk({name, "_idle"}, 128'({ap_idle, flag_o}), 128'({1'b1, flag_i}));
  endtask

  function automatic logic [63:0] rand_op();
    logic [63:0] r;
    logic [51:0] f;
    r = {$urandom, $urandom};
    f = r[51:0];
    case ($urandom_range(0, 4))
      0: r[62:52] = 11'($urandom_range(1, 2046));
      1: r[62:0] = 63'd0;
      2: begin
        f = f >> $urandom_range(0, 51);
        if (f == 0) f = 52'd1;
        r[62:0] = {11'd0, f};
      end
      3: r[62:0] = {11'h7FF, 52'd0};
      default: begin
        if (f == 0) f = 52'd5;
        r[62:0] = {11'h7FF, f};
      end
    endcase
    return r;
  endfunction

  initial begin
    int k;
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    a = 64'd0;
    flag_i = 32'h0000_0102;
    repeat (3) @(negedge ap_clk);
    #1;
    chk_reset_outputs("reset_state");
    ap_rst_n = 1'b1;

    // directed cases
    issue(64'h3FF0_0000_0000_0000, 32'h0); drain();
    issue(64'h0000_0000_0000_0001, 32'h0); drain();
    issue(64'h8008_0000_0000_0000, 32'h4); drain();
    issue(64'h7FF0_0000_0000_0001, 32'h1); drain();
    issue(64'hFFF0_0000_0000_0000, 32'h1); drain();
    issue(64'h7FF8_0000_0000_0001, 32'h8); drain();
    issue(64'h7FEF_FFFF_FFFF_FFFF, 32'h0); drain();
    issue(64'h000F_FFFF_FFFF_FFFF, 32'h0); drain();

    // reset during normalization: no done, outputs cleared
    @(negedge ap_clk);
    a = 64'd1;
    ap_start = 1'b1;
    k = cyc;
    @(negedge ap_clk);
    ap_start = 1'b0;
    while (cyc < k + 10) @(negedge ap_clk);
    ap_rst_n = 1'b0;
    #1;
    chk_reset_outputs("reset_mid_norm");
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    issue(64'h0, 32'h0); drain();

    // start held high across two operands
    @(negedge ap_clk);
    flag_i = 32'h2;
    a = 64'h3FF0_0000_0000_0000;
    ap_start = 1'b1;
    k = cyc;
    exp_q.push_back(model(a, flag_i, k));
    @(negedge ap_clk);
    a = 64'h0;
    exp_q.push_back(model(a, flag_i, k + 2));
    @(negedge ap_clk);
    @(negedge ap_clk);
    ap_start = 1'b0;
    drain();

    // start pulse during NORM is ignored
    issue(64'h0000_0000_0000_0100, 32'h0);
    repeat (3) @(negedge ap_clk);
    a = 64'h4000_0000_0000_0000;
    ap_start = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
    drain();
    repeat (4) @(negedge ap_clk);

    // randomized operands
    for (int i = 0; i < 40; i++) begin
      issue(rand_op(), $urandom);
      drain();
    end
    repeat (3) @(negedge ap_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
